// File: rtl/soc_sysid_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_sysid_arbiter_if
// Brief    : Two Avalon-MM read masters, shared ID-slave port and error flag.
// Revision : 1.0 - initial release
// ============================================================================
interface soc_sysid_arbiter_if;
  logic        m0_read;
  logic        m1_read;
  logic        m0_address;
  logic        m1_address;
  logic [31:0] m0_readdata;
  logic [31:0] m1_readdata;
  logic        m0_readdatavalid;
  logic        m1_readdatavalid;
  logic        m0_waitrequest;
  logic        m1_waitrequest;
  logic        s_read;
  logic        s_address;
  logic [31:0] s_readdata;
  logic        clear_err;
  logic        id_mismatch;

  // Arbiter side.
  modport slave (
    input  m0_read, m1_read, m0_address, m1_address, s_readdata, clear_err,
    output m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid,
           m0_waitrequest, m1_waitrequest, s_read, s_address, id_mismatch
  );

  // Environment side: both requesting masters plus the ID slave.
  modport master (
    output m0_read, m1_read, m0_address, m1_address, s_readdata, clear_err,
    input  m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid,
           m0_waitrequest, m1_waitrequest, s_read, s_address, id_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/soc_sysid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_sysid_arbiter
// Brief    : Round-robin arbiter of two read masters onto a single system-ID
//            slave with fixed read latency and a sticky ID-mismatch flag.
// Revision : 1.0 - initial release
// ============================================================================
module soc_sysid_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] EXPECTED_ID  = 32'h6377_FA27
) (
  input logic                 clk,
  input logic                 rst,
  soc_sysid_arbiter_if.slave  bus
);

  localparam logic [2:0] c_latency = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        w_grant_nxt;
  logic        r_addr;
  logic        w_addr_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_m0_data;
  logic [31:0] r_m1_data;
  logic        r_mismatch;
  logic        w_capture;
  logic        w_set_err;
  logic        w_s_read;
  logic        w_s_address;
  logic        w_m0_rdv;
  logic        w_m1_rdv;
  logic        w_m0_wait;
  logic        w_m1_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_addr_nxt  = r_addr;
    w_capture   = 1'b0;
    w_s_read    = 1'b0;
    w_s_address = 1'b0;
    w_m0_rdv    = 1'b0;
    w_m1_rdv    = 1'b0;
    w_m0_wait   = 1'b1;
    w_m1_wait   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (bus.m0_read || bus.m1_read) begin
          // r_grant remembers the previous winner, so a tie flips it.
          if (bus.m0_read && bus.m1_read) begin
            w_grant_nxt = ~r_grant;
          end else begin
            w_grant_nxt = bus.m1_read;
          end
          w_addr_nxt  = w_grant_nxt ? bus.m1_address : bus.m0_address;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_s_read    = 1'b1;
        w_s_address = r_addr;
        if (c_latency == 3'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_grant) begin
          w_m1_rdv  = 1'b1;
          w_m1_wait = 1'b0;
        end else begin
          w_m0_rdv  = 1'b1;
          w_m0_wait = 1'b0;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_set_err = w_capture && r_addr && (bus.s_readdata != EXPECTED_ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= 1'b1;
      r_addr     <= 1'b0;
      r_cnt      <= 3'd0;
      r_m0_data  <= 32'd0;
      r_m1_data  <= 32'd0;
      r_mismatch <= 1'b0;
    end else begin
      r_grant <= w_grant_nxt;
      r_addr  <= w_addr_nxt;
      if (r_state == S_ISSUE) begin
        r_cnt <= c_latency;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      // Captured straight into the granted master's output register.
      if (w_capture) begin
        if (r_grant) begin
          r_m1_data <= bus.s_readdata;
        end else begin
          r_m0_data <= bus.s_readdata;
        end
      end
      if (w_set_err) begin
        r_mismatch <= 1'b1;
      end else if (bus.clear_err) begin
        r_mismatch <= 1'b0;
      end
    end
  end

  assign bus.s_read           = w_s_read;
  assign bus.s_address        = w_s_address;
  assign bus.m0_readdata      = r_m0_data;
  assign bus.m1_readdata      = r_m1_data;
  assign bus.m0_readdatavalid = w_m0_rdv;
  assign bus.m1_readdatavalid = w_m1_rdv;
  assign bus.m0_waitrequest   = w_m0_wait;
  assign bus.m1_waitrequest   = w_m1_wait;
  assign bus.id_mismatch      = r_mismatch;

endmodule
`default_nettype wire

// File: doc/soc_sysid_arbiter.md
SOC_SYSID_ARBITER -- requirements
Module: soc_sysid_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1: slave readdata is valid this many cycles after the s_read cycle; legal range 0..7.
REQ-002 Parameter EXPECTED_ID, default 32'h6377_FA27: value address 1 must return.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_read, m1_read  in  1  read request from master 0 / master 1 (Avalon-MM, held until the transfer completes).
REQ-006 m0_address, m1_address  in  1  word address requested by each master.
REQ-007 m0_readdata, m1_readdata  out  32  registered response data per master.
REQ-008 m0_readdatavalid, m1_readdatavalid  out  1  one-cycle response strobe per master.
REQ-009 m0_waitrequest, m1_waitrequest  out  1  high stalls the master; low only in that master's response cycle.
REQ-010 s_read  out  1  read strobe to the shared ID slave.
REQ-011 s_address  out  1  address to the shared ID slave.
REQ-012 s_readdata  in  32  slave data.
REQ-013 clear_err  in  1  synchronous clear of id_mismatch.
REQ-014 id_mismatch  out  1  sticky flag: an address-1 read returned a value other than EXPECTED_ID.

Function
REQ-015 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with WAIT skipped when READ_LATENCY=0.
REQ-016 IDLE: if any mX_read is high, the block SHALL latch the grant and the granted address, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requesting, the master not granted last wins; a single requester always wins.
REQ-018 ISSUE: s_read=1 and s_address=latched address for exactly one cycle; the latency counter SHALL load READ_LATENCY.
REQ-019 READ_LATENCY=0: s_readdata SHALL be captured in the ISSUE cycle, then go to RESP.
REQ-020 WAIT: the counter SHALL decrement each cycle; s_readdata SHALL be captured in the last WAIT cycle (READ_LATENCY cycles after ISSUE), then go to RESP.
REQ-021 RESP: for the granted master only, readdata=captured data, readdatavalid=1 and waitrequest=0 for exactly one cycle, then go to IDLE.
REQ-022 Response latency SHALL be exactly 2+READ_LATENCY cycles from the first IDLE cycle with the request sampled high.
REQ-023 The non-granted master SHALL see waitrequest=1 and readdatavalid=0 throughout; its request is served in the next arbitration.
REQ-024 Back-to-back: a master holding read after its RESP SHALL be re-arbitrated in the following IDLE cycle; minimum spacing is 3+READ_LATENCY cycles per transfer.
REQ-025 A request deasserted mid-transfer SHALL NOT abort the sequence; the slave read completes and the RESP strobe still fires.
REQ-026 s_read SHALL never be asserted outside ISSUE; at most one slave read is outstanding.
REQ-027 On capture with latched address 1 and data != EXPECTED_ID, id_mismatch SHALL set and remain set until clear_err.
REQ-028 If a mismatch set and clear_err occur in the same cycle, set SHALL win.
REQ-029 Address-0 reads SHALL never affect id_mismatch.
REQ-030 readdata SHALL hold its last value outside RESP.

Reset
REQ-031 While reset is high: state=IDLE, s_read=0, s_address=0, mX_readdata=0, mX_readdatavalid=0, mX_waitrequest=1, id_mismatch=0, counter=0, last-grant=master 1 (master 0 wins the first tie).
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no RESP strobe; after release the block starts in IDLE.

Verification
REQ-033 L=1, slave returns EXPECTED_ID at address 1, m0 reads address 1 at cycle 0 -> s_read at cycle 1, m0_readdatavalid with 32'h6377_FA27 at cycle 3, id_mismatch=0.
REQ-034 m0 and m1 both request from reset and hold -> grants m0, m1, m0, m1; each RESP 4 cycles apart at L=1.
REQ-035 Slave returns 32'h0 at address 1 -> id_mismatch=1 from the cycle after capture; clear_err pulse -> 0; clear_err coincident with a new mismatch -> stays 1.
REQ-036 L=0 and L=7 sweeps -> RESP at request+2 and request+9; s_read is a single-cycle pulse.
REQ-037 Reset pulse during WAIT -> no readdatavalid, outputs at reset values, next request served normally.
